// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle MIPS control FSM.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWR, MEMWB, RTEX, RWB,
        IEX, IWB, BEQ, J, JAL, JR, HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [1:0] ASB_RT    = 2'd0;
    localparam logic [1:0] ASB_FOUR  = 2'd1;
    localparam logic [1:0] ASB_SEXT  = 2'd2;
    localparam logic [1:0] ASB_SHIFT = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_RS     = 2'd3;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    // Dispatch target after DECODE; FETCH means the opcode is unsupported.
    function automatic state_t decode_op(input logic [5:0] op, input logic [5:0] funct);
        state_t nxt;
        case (op)
            OP_LW, OP_SW: nxt = MEMADR;
            OP_RTYPE:     nxt = (funct == FN_JR) ? JR : RTEX;
            OP_ADDI:      nxt = IEX;
            OP_BEQ:       nxt = BEQ;
            OP_J:         nxt = J;
            OP_JAL:       nxt = JAL;
            default:      nxt = FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_mem_wait.sv
// Memory wait counter: flags a timeout when an access has waited too long.
module mc_mem_wait
    import mc_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ready,
    output logic expire
);

    logic [7:0] cnt;

    // Count stalled request cycles; completion, idle or reset restarts the count
    always_ff @(posedge clk) begin
        if (!rst || !active || ready) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    // A late ready in the final allowed cycle still wins over the timeout
    assign expire = active && !ready && (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM sharing one memory port for fetch and data.
module mc_controller
    import mc_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic [1:0]       regdst,
    output logic [1:0]       wbsel,
    output logic             alusrc_a,
    output logic [1:0]       alusrc_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pcsrc,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret
);

    state_t           state;
    logic             bus_err_q;
    logic [CNT_W-1:0] instret_q;
    logic             expire;
    logic             retire;

    mc_mem_wait #(.TIMEOUT(TIMEOUT)) u_wait (
        .clk    (clk),
        .rst    (rst),
        .active (mem_req),
        .ready  (mem_ready),
        .expire (expire)
    );

    // An instruction retires on the cycle its final state hands back to FETCH
    always_comb begin
        retire = 1'b0;
        case (state)
            MEMWR:                          retire = mem_ready;
            MEMWB, RWB, IWB, BEQ, J, JAL, JR: retire = 1'b1;
            default:                        retire = 1'b0;
        endcase
    end

    // State sequencing, sticky bus error and retired-instruction counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= FETCH;
            bus_err_q <= 1'b0;
            instret_q <= '0;
        end else begin
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
            if (expire) begin
                bus_err_q <= 1'b1;
                state     <= HALT;
            end else begin
                case (state)
                    FETCH:   if (mem_ready) state <= DECODE;
                    DECODE:  state <= decode_op(op, funct);
                    MEMADR:  state <= (op == OP_LW) ? MEMRD : ((op == OP_SW) ? MEMWR : FETCH);
                    MEMRD:   if (mem_ready) state <= MEMWB;
                    MEMWR:   if (mem_ready) state <= FETCH;
                    RTEX:    state <= RWB;
                    IEX:     state <= IWB;
                    MEMWB, RWB, IWB, BEQ, J, JAL, JR: state <= FETCH;
                    HALT:    state <= HALT;
                    default: state <= FETCH;
                endcase
            end
        end
    end

    // Datapath controls decoded from the state; reset forces everything low
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        iord     = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        reg_we   = 1'b0;
        regdst   = RD_RT;
        wbsel    = WB_ALU;
        alusrc_a = 1'b0;
        alusrc_b = ASB_RT;
        alu_op   = ALU_ADD;
        pcsrc    = PCSRC_ALU;
        illegal  = 1'b0;
        if (rst) begin
            case (state)
                FETCH: begin
                    mem_req  = 1'b1;
                    alusrc_b = ASB_FOUR;
                    ir_we    = mem_ready;
                    pc_we    = mem_ready;
                end
                DECODE: begin
                    alusrc_b = ASB_SHIFT;
                    illegal  = (decode_op(op, funct) == FETCH);
                end
                MEMADR, IEX: begin
                    alusrc_a = 1'b1;
                    alusrc_b = ASB_SEXT;
                end
                MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                MEMWR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                end
                MEMWB: begin
                    reg_we = 1'b1;
                    wbsel  = WB_MEM;
                end
                RTEX: begin
                    alusrc_a = 1'b1;
                    alu_op   = ALU_FUNCT;
                end
                RWB: begin
                    reg_we = 1'b1;
                    regdst = RD_RD;
                end
                IWB: reg_we = 1'b1;
                BEQ: begin
                    alusrc_a = 1'b1;
                    alu_op   = ALU_SUB;
                    pcsrc    = PCSRC_ALUOUT;
                    pc_we    = zero;
                end
                J: begin
                    pcsrc = PCSRC_JUMP;
                    pc_we = 1'b1;
                end
                JAL: begin
                    pcsrc  = PCSRC_JUMP;
                    pc_we  = 1'b1;
                    reg_we = 1'b1;
                    regdst = RD_RA;
                    wbsel  = WB_PC;
                end
                JR: begin
                    alusrc_a = 1'b1;
                    pcsrc    = PCSRC_RS;
                    pc_we    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus_err = rst ? bus_err_q : 1'b0;
    assign instret = rst ? instret_q : '0;

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multi-cycle control FSM that sequences the MIPS datapath over a single shared instruction/data memory port.
- Per instruction it issues fetch, decode, execute, memory and writeback steps.
- Drives all datapath enables and mux selects, and runs a req/ready handshake with memory.
- Keeps a retired-instruction counter and detects memory timeouts.

Parameters:
TIMEOUT, 16, max cycles mem_req may stay high without mem_ready before a bus error (range 2..255).
CNT_W, 32, width of the instret counter.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-low
op  in  6  opcode, inst[31:26], taken from the instruction register
funct  in  6  inst[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write qualifier, valid only while mem_req=1
iord  out  1  memory address select: 0 = PC, 1 = ALU result register
ir_we  out  1  load instruction register
pc_we  out  1  load PC
reg_we  out  1  register file write enable
regdst  out  2  write address select: 0 = rt, 1 = rd, 2 = 5'd31
wbsel  out  2  write data select: 0 = ALU, 1 = mem data, 2 = PC (link)
alusrc_a  out  1  ALU A select: 0 = PC, 1 = rs
alusrc_b  out  2  ALU B select: 0 = rt, 1 = 4, 2 = sign-extended imm, 3 = imm<<2
alu_op  out  2  to ALU decoder: 0 = add, 1 = sub, 2 = funct-driven
pcsrc  out  2  PC source: 0 = ALU, 1 = ALU-out register, 2 = jump target, 3 = rs
illegal  out  1  one-cycle pulse on an unsupported opcode
bus_err  out  1  sticky flag, set on memory timeout
instret  out  CNT_W  count of retired instructions

Behaviour:
- Reset (rst=0 at a clock edge):
  - state = FETCH, instret = 0, bus_err = 0, wait counter = 0.
  - While rst=0, all outputs are forced to 0, overriding any state decode.
  - Reset mid-access abandons the access; mem_req drops in the same cycle.
- Default for any output not listed for a state: 0.
- FETCH: mem_req=1, iord=0, alusrc_a=0, alusrc_b=1, alu_op=0, pcsrc=0.
  - On mem_ready: ir_we=1 and pc_we=1 in that same cycle (PC <= PC+4), then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alusrc_a=0, alusrc_b=3, alu_op=0 (branch target goes to the ALU-out register). Dispatch on op:
  - 0x23 (lw) or 0x2B (sw) -> MEMADR
  - 0x00, funct=0x08 (jr) -> JR
  - 0x00, any other funct -> RTEX
  - 0x08 (addi) -> IEX
  - 0x04 (beq) -> BEQ
  - 0x02 (j) -> J
  - 0x03 (jal) -> JAL
  - any other op: illegal=1 for this cycle, then FETCH; the instruction is not retired.
- MEMADR: alusrc_a=1, alusrc_b=2, alu_op=0. Next state MEMRD if op=0x23, MEMWR if op=0x2B.
- MEMRD: mem_req=1, iord=1. On mem_ready go to MEMWB.
- MEMWR: mem_req=1, mem_we=1, iord=1. On mem_ready, retire and go to FETCH.
- MEMWB: reg_we=1, regdst=0, wbsel=1. Retire; go to FETCH.
- RTEX: alusrc_a=1, alusrc_b=0, alu_op=2. Next state RWB.
- RWB: reg_we=1, regdst=1, wbsel=0. Retire; go to FETCH.
- IEX: alusrc_a=1, alusrc_b=2, alu_op=0. Next state IWB.
- IWB: reg_we=1, regdst=0, wbsel=0. Retire; go to FETCH.
- BEQ: alusrc_a=1, alusrc_b=0, alu_op=1, pcsrc=1, pc_we=zero. Retire; go to FETCH.
- J: pcsrc=2, pc_we=1. Retire; go to FETCH.
- JAL: pcsrc=2, pc_we=1, reg_we=1, regdst=2, wbsel=2. Retire; go to FETCH.
  - The PC value written back is the already-incremented PC (PC+4).
- JR: alusrc_a=1, pcsrc=3, pc_we=1. Retire; go to FETCH.
- CPI: R-type/addi = 4 + fetch wait; lw = 5 + 2 waits; sw = 4 + 2 waits; beq/j/jal/jr = 3 + fetch wait. One wait = cycles spent in a memory state before mem_ready.
- Retire: instret increments by 1 on the cycle the FSM leaves a final state.
  - It wraps modulo 2^CNT_W with no saturation.
- mem_ready while mem_req=0 is ignored.
- mem_req, mem_we and iord are held stable from assertion until the mem_ready cycle inclusive.
- Timeout: a wait counter increments each cycle mem_req=1 and mem_ready=0, and clears on mem_ready or on leaving the state.
  - When the counter reaches TIMEOUT-1 with mem_ready still 0: bus_err<=1, next state HALT.
  - mem_ready arriving in that same cycle wins: the access completes and there is no error.
- HALT: all outputs 0, bus_err held at 1. Leaves only through reset.

Decomposition:
- Shared package mc_pkg:
  - state enum: FETCH, DECODE, MEMADR, MEMRD, MEMWR, MEMWB, RTEX, RWB, IEX, IWB, BEQ, J, JAL, JR, HALT
  - opcode and funct constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL, FN_JR)
  - encodings for alusrc_b, pcsrc, wbsel and regdst.
- One sub-module, mc_mem_wait: the wait counter plus timeout compare, with inputs active, ready and outputs expire.

Test Plan:
1. addi $1,$0,5 with mem_ready tied 1 -> states FETCH, DECODE, IEX, IWB; reg_we=1, regdst=0 in cycle 4; instret 0->1; pc_we only in cycle 1.
2. lw with mem_ready delayed 3 cycles in both FETCH and MEMRD -> mem_req high with iord stable each wait; ir_we pulses once; reg_we+wbsel=1 in MEMWB; total 11 cycles.
3. beq with zero=1, then beq with zero=0 -> pc_we=1 with pcsrc=1 in BEQ for the first, pc_we=0 for the second; instret +2.
4. jal then jr -> JAL: pc_we=1, reg_we=1, regdst=2, wbsel=2; JR: pcsrc=3, pc_we=1, reg_we=0.
5. op=0x3F -> illegal pulses for exactly 1 cycle in DECODE; next state FETCH; instret unchanged.
6. mem_ready held 0 in FETCH with TIMEOUT=16 -> bus_err=1 after 16 req cycles and state HALT; then rst=0 for one edge -> bus_err=0, FETCH, mem_req=1 the cycle after rst=1. Separately, ready in the 16th cycle -> no error.
